// File: rtl/subpel_hfilter_stream_if.sv
// Stream interface for the sub-pel horizontal filter.
// master: drives input beats (in_valid/in_row/frac) and out_ready.
// slave : returns in_ready and the filtered output (out_valid/out_row/out_last/row_cnt).
interface subpel_hfilter_stream_if #(
  parameter int unsigned NUM_PIX = 8,
  parameter int unsigned BD      = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [(NUM_PIX+7)*BD-1:0]    in_row;
  logic [1:0]                   frac;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_PIX*BD-1:0]        out_row;
  logic                         out_last;
  logic [7:0]                   row_cnt;

  modport master (
    output in_valid, in_row, frac, out_ready,
    input  in_ready, out_valid, out_row, out_last, row_cnt
  );

  modport slave (
    input  in_valid, in_row, frac, out_ready,
    output in_ready, out_valid, out_row, out_last, row_cnt
  );
endinterface

// File: rtl/subpel_hfilter_stream.sv
// Two-stage streaming 8-tap horizontal sub-pel interpolation filter.
// Ports: clk, rst (async active-low), bus (slave modport):
//   in_valid/in_ready/in_row/frac   - padded input row beats and phase
//   out_valid/out_ready/out_row     - filtered row, two cycles after acceptance
//   out_last                        - last row of a BLK_H-row block
//   row_cnt                         - index of the next input row in the block
module subpel_hfilter_stream #(
  parameter int unsigned NUM_PIX = 8,
  parameter int unsigned BD      = 8,
  parameter int unsigned BLK_H   = 8
) (
  input logic                    clk,
  input logic                    rst,
  subpel_hfilter_stream_if.slave bus
);

  localparam int unsigned NTAP     = 8;
  localparam int unsigned SW       = BD + 8;
  localparam int unsigned OW       = NUM_PIX * BD;
  localparam logic [7:0]  LAST_ROW = 8'(BLK_H - 1);

  typedef logic signed [7:0]    coef_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam coef_t COEF_A [NTAP] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam coef_t COEF_B [NTAP] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam coef_t COEF_C [NTAP] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

  // Coefficient lookup; phase 0 never reaches the tap multiply path.
  function automatic coef_t coef(input logic [1:0] ph, input logic [2:0] k);
    coef_t c;
    case (ph)
      2'd1:    c = COEF_A[k];
      2'd2:    c = COEF_B[k];
      2'd3:    c = COEF_C[k];
      default: c = 8'sd0;
    endcase
    return c;
  endfunction

  // Round with floor shift, then clip to the pixel range.
  function automatic logic [BD-1:0] clip_px(input sum_t s);
    sum_t          r;
    logic [BD-1:0] p;
    r = (s + sum_t'(32)) >>> 6;
    if (r[SW-1]) begin
      p = '0;
    end else if (|r[SW-2:BD]) begin
      p = '1;
    end else begin
      p = r[BD-1:0];
    end
    return p;
  endfunction

  logic          rdy_en_q,   rdy_en_d;
  logic [7:0]    row_cnt_q,  row_cnt_d;
  logic [1:0]    phase_q,    phase_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q,  s1_last_d;
  sum_t          s1_sum_q [NUM_PIX];
  sum_t          s1_sum_d [NUM_PIX];
  logic          s2_valid_q, s2_valid_d;
  logic          s2_last_q,  s2_last_d;
  logic [OW-1:0] out_row_q,  out_row_d;

  logic          advance_c;
  logic          accept_c;
  logic          row_last_c;
  logic [1:0]    eff_phase_c;
  sum_t          tap_sum_c [NUM_PIX];

  // Whole pipeline stalls only when S2 holds data nobody takes.
  assign advance_c    = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = advance_c && rdy_en_q;
  assign accept_c     = bus.in_valid && advance_c && rdy_en_q;
  assign row_last_c   = (row_cnt_q == LAST_ROW);
  // Row 0 uses the live frac (it is being latched now); later rows use the held phase.
  assign eff_phase_c  = (row_cnt_q == 8'd0) ? bus.frac : phase_q;

  // Per-lane tap sums; integer phase is pre-scaled by 64 so round/clip passes it through.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PIX; i++) begin
      tap_sum_c[i] = '0;
      if (eff_phase_c == 2'd0) begin
        tap_sum_c[i] = sum_t'({8'b0, bus.in_row[(i+3)*BD +: BD]}) <<< 6;
      end else begin
        for (int unsigned k = 0; k < NTAP; k++) begin
          tap_sum_c[i] = tap_sum_c[i]
                       + sum_t'({8'b0, bus.in_row[(i+k)*BD +: BD]})
                       * sum_t'(coef(eff_phase_c, 3'(k)));
        end
      end
    end
  end

  // Next-state: pipeline advance, row framing and phase capture.
  always_comb begin
    rdy_en_d   = 1'b1;
    row_cnt_d  = row_cnt_q;
    phase_d    = phase_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_sum_d   = s1_sum_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    out_row_d  = out_row_q;

    if (advance_c) begin
      s1_valid_d = accept_c;
      s1_last_d  = accept_c && row_last_c;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (accept_c) begin
        s1_sum_d = tap_sum_c;
      end
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < NUM_PIX; i++) begin
          out_row_d[i*BD +: BD] = clip_px(s1_sum_q[i]);
        end
      end
    end

    if (accept_c) begin
      row_cnt_d = row_last_c ? 8'd0 : row_cnt_q + 8'd1;
      if (row_cnt_q == 8'd0) begin
        phase_d = bus.frac;
      end
    end
  end

  // State registers; rdy_en_q keeps input closed for the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q   <= 1'b0;
      row_cnt_q  <= 8'd0;
      phase_q    <= 2'd0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      out_row_q  <= '0;
      for (int unsigned i = 0; i < NUM_PIX; i++) begin
        s1_sum_q[i] <= '0;
      end
    end else begin
      rdy_en_q   <= rdy_en_d;
      row_cnt_q  <= row_cnt_d;
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      out_row_q  <= out_row_d;
      for (int unsigned i = 0; i < NUM_PIX; i++) begin
        s1_sum_q[i] <= s1_sum_d[i];
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_last  = s2_valid_q && s2_last_q;
  assign bus.out_row   = out_row_q;
  assign bus.row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_subpel_hfilter_stream.sv
// Directed bench for subpel_hfilter_stream: reset, flat/clip, integer phase,
// backpressure, block framing and mid-block reset, with hand-computed expectations.
module tb_subpel_hfilter_stream;

  localparam int unsigned NUM_PIX = 8;
  localparam int unsigned BD      = 8;
  localparam int unsigned BLK_H   = 8;
  localparam int unsigned IW      = (NUM_PIX + 7) * BD;
  localparam int unsigned OW      = NUM_PIX * BD;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   tx;
  int   rx;

  subpel_hfilter_stream_if #(.NUM_PIX(NUM_PIX), .BD(BD)) bus ();

  subpel_hfilter_stream #(.NUM_PIX(NUM_PIX), .BD(BD), .BLK_H(BLK_H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Input row with pixel k = base + step*k.
  function automatic logic [IW-1:0] ramp(input int unsigned base, input int unsigned step);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_PIX + 7; k++) r[k*BD +: BD] = BD'(base + step * k);
    return r;
  endfunction

  // Input row with pixel k = 255 where m[k] is set, else 0.
  function automatic logic [IW-1:0] masked(input logic [NUM_PIX+6:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_PIX + 7; k++) r[k*BD +: BD] = {BD{m[k]}};
    return r;
  endfunction

  // Expected output row with lane i = base + step*i.
  function automatic logic [OW-1:0] lanes(input int unsigned base, input int unsigned step);
    logic [OW-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < NUM_PIX; i++) e[i*BD +: BD] = BD'(base + step * i);
    return e;
  endfunction

  task automatic rst_block();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One full block of ramp(0,4) rows; frac only meaningful on row 0.
  task automatic run_block(input logic [1:0] f0, input logic [63:0] expv, input string tag);
    for (int b = 0; b < int'(BLK_H) + 2; b++) begin
      bus.in_valid = (b < int'(BLK_H));
      bus.frac     = (b == 0) ? f0 : 2'(b);
      bus.in_row   = ramp(0, 4);
      @(negedge clk);
      if (b >= 1 && b <= int'(BLK_H)) begin
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_row"},   64'(bus.out_row),   expv);
        chk({tag, "_last"},  64'(bus.out_last),  64'(b == int'(BLK_H)));
      end
    end
    chk({tag, "_rowcnt_wrap"}, 64'(bus.row_cnt),   64'd0);
    chk({tag, "_drained"},     64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_row    = '0;
    bus.frac      = 2'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_out_row",   64'(bus.out_row),   64'd0);
    chk("rst_row_cnt",   64'(bus.row_cnt),   64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);

    // Release with a beat already offered: first edge must not take it.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.frac     = 2'd2;
    bus.in_row   = ramp(100, 0);
    @(negedge clk);
    chk("sync_row_cnt",  64'(bus.row_cnt),   64'd0);
    chk("sync_in_ready", 64'(bus.in_ready),  64'd1);
    chk("sync_out_vld",  64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat1_out_vld",  64'(bus.out_valid), 64'd0);
    chk("lat1_row_cnt",  64'(bus.row_cnt),   64'd1);
    bus.frac   = 2'd0;
    bus.in_row = masked(15'h005A);
    @(negedge clk);
    chk("flat_valid", 64'(bus.out_valid), 64'd1);
    chk("flat_row",   64'(bus.out_row),   lanes(100, 0));
    chk("flat_last",  64'(bus.out_last),  64'd0);
    bus.in_row = masked(15'h00A5);
    @(negedge clk);
    chk("clip_hi_row", 64'(bus.out_row), 64'h0000_1000_AB83_44FF);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clip_lo_row", 64'(bus.out_row), 64'h0010_00AF_7470_BF00);
    chk("clip_rowcnt", 64'(bus.row_cnt), 64'd3);
    @(negedge clk);
    chk("clip_drained", 64'(bus.out_valid), 64'd0);

    // Integer phase block with a 5-cycle stall mid-stream.
    rst_block();
    tx = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      bus.out_ready = !(c >= 4 && c < 9);
      bus.in_valid  = (tx < 8);
      bus.in_row    = ramp(32'(tx) * 16, 1);
      bus.frac      = (tx == 0) ? 2'd0 : 2'(tx % 3 + 1);
      #1;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          chk("bp_data", 64'(bus.out_row),  lanes(32'(rx) * 16 + 3, 1));
          chk("bp_last", 64'(bus.out_last), 64'(rx == 7));
          rx++;
        end else begin
          chk("bp_hold_row", 64'(bus.out_row),  lanes(32'(rx) * 16 + 3, 1));
          chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
        end
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(negedge clk);
    end
    chk("bp_rx_count", 64'(rx), 64'd8);
    chk("bp_tx_count", 64'(tx), 64'd8);
    chk("bp_row_cnt",  64'(bus.row_cnt), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Filter A on row 0, other phases offered mid-block must be ignored.
    rst_block();
    run_block(2'd1, lanes(13, 4), "blkA");

    // Reset after three accepted beats.
    rst_block();
    for (int b = 0; b < 3; b++) begin
      bus.in_valid = 1'b1;
      bus.frac     = 2'd2;
      bus.in_row   = ramp(100, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("mr_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_last",  64'(bus.out_last),  64'd0);
    chk("mr_out_row",   64'(bus.out_row),   64'd0);
    chk("mr_row_cnt",   64'(bus.row_cnt),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    run_block(2'd3, lanes(15, 4), "postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
